// File: rtl/map_ram.sv
// Writable tile-map store: built-in border/empty init sequencer, 1-cycle registered read port,
// game-logic write port with dropped-write error pulse, and out-of-bounds read substitution.
module map_ram #(
  parameter int MAP_W_LOG2   = 3,
  parameter int MAP_H_LOG2   = 3,
  parameter int CELL_W       = 2,
  parameter int BORDER_VALUE = 1,
  parameter int OOB_VALUE    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  rd_en,
  input  logic [MAP_W_LOG2:0]   rd_x,
  input  logic [MAP_H_LOG2:0]   rd_y,
  output logic                  rd_valid,
  output logic [CELL_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [MAP_W_LOG2:0]   wr_x,
  input  logic [MAP_H_LOG2:0]   wr_y,
  input  logic [CELL_W-1:0]     wr_data,
  output logic                  wr_err
);

  localparam int AW = MAP_W_LOG2 + MAP_H_LOG2;
  localparam int N  = 1 << AW;
  localparam logic [CELL_W-1:0] LP_BORDER = CELL_W'(BORDER_VALUE);
  localparam logic [CELL_W-1:0] LP_OOB    = CELL_W'(OOB_VALUE);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t              r_state, w_state_nxt;
  logic [AW-1:0]       r_cnt, w_cnt_nxt;
  logic [CELL_W-1:0]   r_mem [N];

  logic                    w_ready, w_last, w_init_wr, w_is_border;
  logic [MAP_W_LOG2-1:0]   w_init_x;
  logic [MAP_H_LOG2-1:0]   w_init_y;
  logic [CELL_W-1:0]       w_init_val;
  logic                    w_rd_oob, w_wr_oob, w_rd_go, w_wr_ok;
  logic [AW-1:0]           w_rd_addr, w_wr_addr;

  assign w_ready     = (r_state == S_READY);
  assign w_last      = (r_cnt == AW'(N - 1));
  assign w_init_x    = r_cnt[MAP_W_LOG2-1:0];
  assign w_init_y    = r_cnt[AW-1:MAP_W_LOG2];
  assign w_is_border = (w_init_x == '0) || (w_init_x == '1) ||
                       (w_init_y == '0) || (w_init_y == '1);
  assign w_init_val  = w_is_border ? LP_BORDER : '0;
  assign w_init_wr   = (r_state == S_INIT) && !rst;

  assign w_rd_oob  = rd_x[MAP_W_LOG2] | rd_y[MAP_H_LOG2];
  assign w_wr_oob  = wr_x[MAP_W_LOG2] | wr_y[MAP_H_LOG2];
  assign w_rd_addr = {rd_y[MAP_H_LOG2-1:0], rd_x[MAP_W_LOG2-1:0]};
  assign w_wr_addr = {wr_y[MAP_H_LOG2-1:0], wr_x[MAP_W_LOG2-1:0]};
  assign w_rd_go   = rd_en && w_ready && !rst;
  // An init_start in the same cycle claims the array, so the write loses.
  assign w_wr_ok   = wr_en && w_ready && !init_start && !w_wr_oob && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    init_busy   = 1'b0;
    init_done   = 1'b0;
    case (r_state)
      S_INIT: begin
        init_busy = 1'b1;
        w_cnt_nxt = r_cnt + 1'b1;
        if (w_last) begin
          init_done   = 1'b1;
          w_state_nxt = S_READY;
          w_cnt_nxt   = '0;
        end
      end
      S_READY: begin
        if (init_start) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
    endcase
    if (rst) begin
      init_busy = 1'b1;
      init_done = 1'b0;
    end
  end

  // Contents are deliberately not reset; the sequencer defines them.
  always_ff @(posedge clk) begin
    if (w_init_wr)
      r_mem[r_cnt] <= w_init_val;
    else if (w_wr_ok)
      r_mem[w_wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      wr_err   <= 1'b0;
    end else begin
      rd_valid <= w_rd_go;
      if (w_rd_go)
        rd_data <= w_rd_oob ? LP_OOB : r_mem[w_rd_addr];
      wr_err <= wr_en && !w_wr_ok;
    end
  end

endmodule

// File: tb/tb_map_ram.sv
// Self-checking bench for map_ram: directed scenarios plus randomized traffic
// compared against a 2-D array model of the tile map.
module tb_map_ram;

  logic       clk = 1'b0;
  logic       rst, init_start, init_busy, init_done;
  logic       rd_en, rd_valid, wr_en, wr_err;
  logic [3:0] rd_x, rd_y, wr_x, wr_y;
  logic [1:0] rd_data, wr_data;

  always #5 clk = ~clk;

  map_ram dut (
    .clk(clk), .rst(rst), .init_start(init_start),
    .init_busy(init_busy), .init_done(init_done),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_err(wr_err)
  );

  int checks = 0;
  int errors = 0;
  int model [8][8];
  int exp_last;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pattern(input int x, input int y);
    return (x == 0 || x == 7 || y == 0 || y == 7) ? 1 : 0;
  endfunction

  function automatic int exp_read(input int x, input int y);
    if (x > 7 || y > 7) return 1;
    return model[y][x];
  endfunction

  task automatic model_init();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        model[y][x] = pattern(x, y);
  endtask

  task automatic cycle(input logic re, input int rx, input int ry,
                       input logic we, input int wx, input int wy, input int wd,
                       input logic is,
                       output logic v, output int d, output logic e);
    rd_en = re; rd_x = 4'(rx); rd_y = 4'(ry);
    wr_en = we; wr_x = 4'(wx); wr_y = 4'(wy); wr_data = 2'(wd);
    init_start = is;
    step();
    v = rd_valid; d = int'(rd_data); e = wr_err;
    rd_en = 1'b0; wr_en = 1'b0; init_start = 1'b0;
  endtask

  task automatic count_init(output int busy, output int dcnt, output int didx);
    busy = 0; dcnt = 0; didx = -1;
    for (int i = 0; i < 200; i++) begin
      if (!init_busy) break;
      busy++;
      if (init_done) begin dcnt++; didx = busy; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; init_start = 0; rd_en = 0; wr_en = 0;
    rd_x = 0; rd_y = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    step(); step(); step();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", init_busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", init_done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 2'd0) begin errors++; $display("FAIL reset_rd_data: got %0d expected 0", rd_data); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
  endtask

  task automatic test_init_timing();
    int busy, dcnt, didx;
    rst = 1'b0;
    count_init(busy, dcnt, didx);
    model_init();
    checks++; if (busy != 64) begin errors++; $display("FAIL init_busy_cycles: got %0d expected 64", busy); end
    checks++; if (dcnt != 1 || didx != 64) begin errors++; $display("FAIL init_done_pulse: got count %0d at %0d expected 1 at 64", dcnt, didx); end
  endtask

  task automatic test_fixed_reads();
    int xs [4] = '{0, 7, 3, 4};
    int ys [4] = '{0, 3, 3, 6};
    int ex [4] = '{1, 1, 0, 0};
    logic v, e; int d;
    for (int i = 0; i < 4; i++) begin
      cycle(1, xs[i], ys[i], 0, 0, 0, 0, 0, v, d, e);
      checks++; if (v !== 1'b1 || d != ex[i]) begin errors++; $display("FAIL fixed_read(%0d,%0d): got valid %b data %0d expected valid 1 data %0d", xs[i], ys[i], v, d, ex[i]); end
    end
    step();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_idle: got %b expected 0", rd_valid); end
  endtask

  task automatic test_write_read();
    logic v, e; int d;
    cycle(0, 0, 0, 1, 3, 5, 2, 0, v, d, e);
    model[5][3] = 2;
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL write_ok_err: got %b expected 0", e); end
    cycle(1, 3, 5, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (v !== 1'b1 || d != 2) begin errors++; $display("FAIL write_then_read: got %0d expected 2", d); end
    cycle(1, 2, 2, 1, 2, 2, 3, 0, v, d, e);
    checks++; if (d != 0) begin errors++; $display("FAIL read_first: got %0d expected 0", d); end
    model[2][2] = 3;
    cycle(1, 2, 2, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (d != 3) begin errors++; $display("FAIL read_after_same_cycle_write: got %0d expected 3", d); end
  endtask

  task automatic test_oob();
    logic v, e; int d;
    cycle(1, 8, 2, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (v !== 1'b1 || d != 1) begin errors++; $display("FAIL oob_read_x: got %0d expected 1", d); end
    cycle(1, 1, 9, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (v !== 1'b1 || d != 1) begin errors++; $display("FAIL oob_read_y: got %0d expected 1", d); end
    cycle(0, 0, 0, 1, 8, 0, 2, 0, v, d, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oob_write_err: got %b expected 1", e); end
    cycle(1, 0, 0, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (d != 1 || e !== 1'b0) begin errors++; $display("FAIL oob_write_no_effect: got data %0d err %b expected 1 0", d, e); end
  endtask

  task automatic test_random();
    logic v, e, re, we; int d, rx, ry, wx, wy, wd, exp_d, exp_e;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, v, d, e);
    exp_last = exp_read(0, 0);
    checks++; if (d != exp_last) begin errors++; $display("FAIL random_seed_read: got %0d expected %0d", d, exp_last); end
    for (int i = 0; i < 300; i++) begin
      re = 1'($urandom_range(1, 0)); we = 1'($urandom_range(1, 0));
      rx = $urandom_range(9, 0); ry = $urandom_range(9, 0);
      wx = $urandom_range(9, 0); wy = $urandom_range(9, 0); wd = $urandom_range(3, 0);
      exp_d = re ? exp_read(rx, ry) : exp_last;
      exp_e = (we && (wx > 7 || wy > 7)) ? 1 : 0;
      cycle(re, rx, ry, we, wx, wy, wd, 0, v, d, e);
      if (we && wx <= 7 && wy <= 7) model[wy][wx] = wd;
      exp_last = exp_d;
      checks++;
      if (v !== re || d != exp_d || int'(e) != exp_e) begin
        errors++;
        $display("FAIL random_cycle_%0d: got valid %b data %0d err %b expected %b %0d %0d", i, v, d, e, re, exp_d, exp_e);
      end
    end
  endtask

  task automatic test_access_during_init();
    logic v, e; int d, busy, dcnt, didx;
    busy = 0; dcnt = 0; didx = -1;
    cycle(0, 0, 0, 1, 1, 1, 3, 1, v, d, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL init_start_wins_err: got %b expected 1", e); end
    for (int i = 0; i < 200; i++) begin
      if (!init_busy) break;
      busy++;
      if (init_done) begin dcnt++; didx = busy; end
      if (busy == 10) begin
        cycle(1, 2, 3, 1, 2, 3, 3, 0, v, d, e);
        checks++; if (v !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL access_in_init: got valid %b err %b expected 0 1", v, e); end
      end else begin
        step();
      end
    end
    model_init();
    checks++; if (busy != 64 || dcnt != 1 || didx != 64) begin errors++; $display("FAIL reinit_timing: got busy %0d done %0d at %0d expected 64 1 64", busy, dcnt, didx); end
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        cycle(1, x, y, 0, 0, 0, 0, 0, v, d, e);
        checks++; if (d != model[y][x]) begin errors++; $display("FAIL pattern(%0d,%0d): got %0d expected %0d", x, y, d, model[y][x]); end
      end
  endtask

  task automatic test_rst_mid_init();
    logic v, e; int d, busy, dcnt, didx;
    cycle(0, 0, 0, 0, 0, 0, 0, 1, v, d, e);
    for (int i = 0; i < 30; i++) step();
    checks++; if (init_busy !== 1'b1) begin errors++; $display("FAIL busy_mid_init: got %b expected 1", init_busy); end
    rst = 1'b1;
    step();
    checks++; if (init_busy !== 1'b1 || init_done !== 1'b0) begin errors++; $display("FAIL busy_during_rst: got busy %b done %b expected 1 0", init_busy, init_done); end
    rst = 1'b0;
    count_init(busy, dcnt, didx);
    checks++; if (busy != 64 || dcnt != 1 || didx != 64) begin errors++; $display("FAIL rst_restart_timing: got busy %0d done %0d at %0d expected 64 1 64", busy, dcnt, didx); end
    model_init();
    cycle(0, 0, 0, 1, 3, 3, 2, 0, v, d, e);
    cycle(1, 3, 3, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (d != 2) begin errors++; $display("FAIL write_before_reinit: got %0d expected 2", d); end
    cycle(0, 0, 0, 0, 0, 0, 0, 1, v, d, e);
    count_init(busy, dcnt, didx);
    checks++; if (busy != 64 || dcnt != 1) begin errors++; $display("FAIL init_start_timing: got busy %0d done %0d expected 64 1", busy, dcnt); end
    cycle(1, 3, 3, 0, 0, 0, 0, 0, v, d, e);
    checks++; if (d != 0) begin errors++; $display("FAIL reinit_clears_cell: got %0d expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_init_timing();
    test_fixed_reads();
    test_write_read();
    test_oob();
    test_random();
    test_access_during_init();
    test_rst_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
